// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants, ALU operation codes and datapath select values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Internal ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand selects
  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  // PC source selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True for the load/store opcodes that share the address-calculation state
  function automatic logic is_mem_op(input logic [5:0] op_v);
    return (op_v == OP_LW) || (op_v == OP_SW);
  endfunction

endpackage

// File: rtl/mc_alu_ctl.sv
// ALU decoder: maps the FSM's ALU operation class plus the funct field to
// the 3-bit ALU operation, and flags funct codes that are not decodable.
module mc_alu_ctl
  import mc_ctrl_pkg::*;
#(
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3
) (
  input  logic [1:0]          alu_op,
  input  logic [FUNCT_W-1:0]  funct,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                funct_illegal
);

  // Decode ALU operation; unknown funct falls back to add and is flagged
  always_comb begin
    alu_ctl       = ALU_ADD;
    funct_illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctl = ALU_ADD;
      ALUOP_SUB: alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctl = ALU_ADD;
          FN_SUB:  alu_ctl = ALU_SUB;
          FN_AND:  alu_ctl = ALU_AND;
          FN_OR:   alu_ctl = ALU_OR;
          FN_SLT:  alu_ctl = ALU_SLT;
          default: begin
            alu_ctl       = ALU_ADD;
            funct_illegal = 1'b1;
          end
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control unit: sequences each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath strobes.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W     = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUCTL_W = 3,
  parameter bit EN_ADDI  = 1'b1,
  parameter bit EN_JUMP  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALUCTL_W-1:0] alu_ctl,
  output logic                illegal_op,
  output logic [3:0]          state_o
);

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] alu_op_s;
  logic       funct_illegal_s;

  mc_alu_ctl #(
    .FUNCT_W  (FUNCT_W),
    .ALUCTL_W (ALUCTL_W)
  ) u_alu_ctl (
    .alu_op        (alu_op_s),
    .funct         (funct),
    .alu_ctl       (alu_ctl),
    .funct_illegal (funct_illegal_s)
  );

  assign state_o = state_r;

  // State register with asynchronous return to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; memory states hold until the access completes
  always_comb begin
    next_state_s = S_IDLE;
    case (state_r)
      S_IDLE:  next_state_s = S_FETCH;
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        if (op == OP_RTYPE)                 next_state_s = S_EXEC;
        else if (is_mem_op(op))             next_state_s = S_MEM_ADDR;
        else if (op == OP_BEQ)              next_state_s = S_BRANCH;
        else if (EN_JUMP && (op == OP_J))   next_state_s = S_JUMP;
        else if (EN_ADDI && (op == OP_ADDI)) next_state_s = S_ADDI_EX;
        else                                next_state_s = S_TRAP;
      end
      S_MEM_ADDR: begin
        if (op == OP_LW) next_state_s = S_MEM_RD;
        else             next_state_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (mem_ready) next_state_s = S_MEM_WB;
        else           next_state_s = S_MEM_RD;
      end
      S_MEM_WB: next_state_s = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEM_WR;
      end
      S_EXEC: begin
        if (funct_illegal_s) next_state_s = S_TRAP;
        else                 next_state_s = S_R_WB;
      end
      S_R_WB:    next_state_s = S_FETCH;
      S_BRANCH:  next_state_s = S_FETCH;
      S_JUMP:    next_state_s = S_FETCH;
      S_ADDI_EX: next_state_s = S_ADDI_WB;
      S_ADDI_WB: next_state_s = S_FETCH;
      S_TRAP:    next_state_s = S_FETCH;
      default:   next_state_s = S_IDLE;
    endcase
  end

  // Moore output decode; FETCH gates its PC/IR writes with mem_ready
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    pc_source     = PC_SRC_ALU;
    alu_op_s      = ALUOP_ADD;
    illegal_op    = 1'b0;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_DECODE: alu_src_b = SRC_B_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op_s  = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op_s      = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: illegal_op = 1'b0;
    endcase
  end

endmodule
